interval_timer_ctrl: RTL and testbench
======================================

INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the controlled counter and of the reload register.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-003 SHALL have port nReset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port regWrite, input, 1: register write strobe, one write per cycle.
REQ-005 SHALL have port regAddr, input, 1: register select; 0 = reload, 1 = control/status.
REQ-006 SHALL have port regDataIn, input, WIDTH: write data.
REQ-007 SHALL have port regDataOut, output, WIDTH: combinational read data.
REQ-008 SHALL have port irqAck, input, 1: clears the expired flag.
REQ-009 SHALL have port irq, output, 1: interrupt request.
REQ-010 SHALL have port counterValue, input, WIDTH: current count from the up-counter.
REQ-011 SHALL have port counterCarry, input, 1: counter carry out, high when the count is all ones.
REQ-012 SHALL have port counterLoad, output, WIDTH: per-bit load mask; all bits always equal.
REQ-013 SHALL have port counterValueIn, output, WIDTH: always equal to the reload register.
REQ-014 SHALL have port counterClkEn, output, 1: counter clock enable.

Function
REQ-015 SHALL provide the following registers.
- Reload register at address 0; read returns counterValue.
- Control register at address 1: bit0 enable, bit1 periodic, bit2 irqEn.
- Read of address 1 returns bit0 running (state != IDLE), bit1 expired, bit2 irqEn; all other bits 0.
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-017 SHALL use these IDLE outputs: counterClkEn=0, counterLoad=0.
- A control write with enable=1 moves to LOAD on the next edge.
REQ-018 SHALL use these LOAD outputs for exactly one cycle: counterLoad all ones, counterClkEn=1; then go to RUN.
REQ-019 SHALL drive counterClkEn=tick in RUN (tick defined in REQ-028/029).
REQ-020 SHALL treat tick & counterCarry in RUN as expiry.
- The expired flag sets on the same edge.
- If periodic=1: counterLoad is all ones combinationally in that same cycle, so the count reloads with no dead cycle; the FSM stays in RUN.
- If periodic=0: the FSM goes to DONE.
REQ-021 SHALL hold the count in DONE with counterClkEn=0, until a control write.
REQ-022 SHALL, for a control write with enable=0 in any state, go to IDLE on the next edge; the expired flag is unchanged.
- A control write with enable=1 in RUN or DONE restarts via LOAD.
REQ-023 SHALL update the reload register immediately on write; in RUN the new value takes effect only at the next reload.
REQ-024 SHALL give expiry priority over irqAck when both occur in the same cycle (flag remains set).
REQ-025 SHALL drive irq = expired & irqEn, registered-flag based with no combinational path from inputs.
REQ-026 SHALL make the period (2^WIDTH - reload) ticks; reload all ones gives a period of 1 tick.

Reset
REQ-027 SHALL, while nReset=0, asynchronously force all of the following:
- state IDLE;
- reload, control and expired cleared;
- prescaler counter cleared;
- irq=0, counterClkEn=0, counterLoad=0, counterValueIn=0.
- Deassertion mid-count leaves the counter disabled until a new enable write.

Configuration
REQ-028 SHALL, with TIMER_PRESCALER_EN defined:
- use control bits [15:8] as a prescale value P, readable at the same bits;
- generate tick once every P+1 cycles from an 8-bit down-counter;
- reload that down-counter to P in LOAD and on every tick;
- for P=0, make tick=1 every cycle.
REQ-029 SHALL, without TIMER_PRESCALER_EN, make tick=1 constantly; control bits [15:8] are ignored and read as 0.

Verification
REQ-030 SHALL cover one-shot expiry.
- Stimulus: reload=0xFFFC, control=0x5.
- Response: counterClkEn starts after the LOAD cycle; expired and irq are set after 4 RUN cycles; FSM in DONE; counterValue holds 0x0000.
REQ-031 SHALL cover periodic mode.
- Stimulus: reload=0xFFFE, control=0x3.
- Response: counterLoad pulses every 2 cycles with no gap; counterValue sequence FFFE, FFFF, FFFE, FFFF.
REQ-032 SHALL cover the ack/expiry collision.
- Stimulus: irqAck asserted in the same cycle as expiry.
- Response: expired remains 1; an ack the next cycle clears it and irq falls.
REQ-033 SHALL cover disable and reset mid-run.
- Stimulus: control=0x0 written at count 0xFFF0.
- Response: IDLE next edge; the count freezes.
- Stimulus: nReset pulsed low during RUN.
- Response: all outputs 0 immediately, with no clock edge needed.
REQ-034 SHALL cover the prescaler (TIMER_PRESCALER_EN only).
- Stimulus: P=3, reload=0xFFFF, one-shot.
- Response: expiry occurs 4 cycles after LOAD.

Source files
------------

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
//   Controls an external WIDTH-bit up-counter to form an interval timer with
//   one-shot and periodic modes, an expired flag and an interrupt output.
//
//   Optional feature macro: TIMER_PRESCALER_EN
//     defined   : control bits [15:8] hold a prescale value P; the counter
//                 advances once every P+1 cycles (requires WIDTH >= 16).
//     undefined : the counter advances every cycle; bits [15:8] read as 0.
//
//   Ports
//     clk            : clock, all state changes on the rising edge
//     nReset         : asynchronous active-low reset
//     regWrite       : register write strobe
//     regAddr        : 0 = reload register, 1 = control/status register
//     regDataIn      : write data
//     regDataOut     : combinational read data (addr 0 -> counterValue,
//                      addr 1 -> {P, 5'b0, irqEn, expired, running})
//     irqAck         : clears the expired flag
//     irq            : expired & irqEn
//     counterValue   : current count from the external counter
//     counterCarry   : counter carry out (count is all ones)
//     counterLoad    : per-bit load mask, all bits equal
//     counterValueIn : load value, always the reload register
//     counterClkEn   : counter clock enable
module interval_timer_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             regWrite,
  input  logic             regAddr,
  input  logic [WIDTH-1:0] regDataIn,
  output logic [WIDTH-1:0] regDataOut,
  input  logic             irqAck,
  output logic             irq,
  input  logic [WIDTH-1:0] counterValue,
  input  logic             counterCarry,
  output logic [WIDTH-1:0] counterLoad,
  output logic [WIDTH-1:0] counterValueIn,
  output logic             counterClkEn
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             periodic;
  logic             irq_en;
  logic             expired;

  logic             ctrl_wr;
  logic             reload_wr;
  logic             tick;
  logic             expiry;
  logic             load_now;
  logic [WIDTH-1:0] status;

  assign ctrl_wr   = regWrite & regAddr;
  assign reload_wr = regWrite & ~regAddr;

  // Expiry is the tick on which the counter sits at all ones.
  assign expiry = (state == RUN) & tick & counterCarry;

`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc;
  logic [7:0] presc_cnt;

  // Down-counter: tick when it reaches zero, then restart from P. It is
  // primed in LOAD so the first RUN tick comes P+1 cycles after LOAD.
  assign tick = (presc_cnt == 8'd0);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else begin
      if (ctrl_wr) begin
        presc <= regDataIn[15:8];
      end
      if (state == LOAD) begin
        presc_cnt <= presc;
      end else if (state == RUN) begin
        presc_cnt <= tick ? presc : presc_cnt - 8'd1;
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      reload   <= '0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      expired  <= 1'b0;
    end else begin
      if (reload_wr) begin
        reload <= regDataIn;
      end

      if (ctrl_wr) begin
        periodic <= regDataIn[1];
        irq_en   <= regDataIn[2];
      end

      // Expiry wins over a simultaneous acknowledge.
      if (expiry) begin
        expired <= 1'b1;
      end else if (irqAck) begin
        expired <= 1'b0;
      end

      // A control write overrides every other transition, including an
      // expiry in the same cycle.
      if (ctrl_wr) begin
        state <= regDataIn[0] ? LOAD : IDLE;
      end else begin
        unique case (state)
          LOAD:    state <= RUN;
          RUN:     if (expiry && !periodic) state <= DONE;
          default: ;
        endcase
      end
    end
  end

  // Counter controls decode from the state register; the periodic reload
  // is asserted in the expiry cycle itself so the next count is the reload
  // value with no dead cycle.
  always_comb begin
    counterClkEn = 1'b0;
    load_now     = 1'b0;
    unique case (state)
      LOAD: begin
        counterClkEn = 1'b1;
        load_now     = 1'b1;
      end
      RUN: begin
        counterClkEn = tick;
        load_now     = expiry & periodic;
      end
      default: ;
    endcase
  end

  assign counterLoad    = {WIDTH{load_now}};
  assign counterValueIn = reload;
  assign irq            = expired & irq_en;

  always_comb begin
    status    = '0;
    status[0] = (state != IDLE);
    status[1] = expired;
    status[2] = irq_en;
`ifdef TIMER_PRESCALER_EN
    status[15:8] = presc;
`endif
    regDataOut = regAddr ? status : counterValue;
  end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Bench for interval_timer_ctrl: models the external up-counter, and keeps a
// reference of the timer in terms of "ticks left until expiry" rather than
// the counter's carry. Directed scenarios first, then randomized traffic.
module tb_interval_timer_ctrl;
  localparam int unsigned W = 16;
  localparam logic [W-1:0] ONES = '1;

  logic         clk = 1'b0;
  logic         nReset;
  logic         regWrite;
  logic         regAddr;
  logic [W-1:0] regDataIn;
  logic [W-1:0] regDataOut;
  logic         irqAck;
  logic         irq;
  logic [W-1:0] counterValue;
  logic         counterCarry;
  logic [W-1:0] counterLoad;
  logic [W-1:0] counterValueIn;
  logic         counterClkEn;

  always #5 clk = ~clk;

  interval_timer_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .nReset         (nReset),
    .regWrite       (regWrite),
    .regAddr        (regAddr),
    .regDataIn      (regDataIn),
    .regDataOut     (regDataOut),
    .irqAck         (irqAck),
    .irq            (irq),
    .counterValue   (counterValue),
    .counterCarry   (counterCarry),
    .counterLoad    (counterLoad),
    .counterValueIn (counterValueIn),
    .counterClkEn   (counterClkEn)
  );

  // External up-counter
  logic [W-1:0] cnt;
  assign counterValue = cnt;
  assign counterCarry = (cnt == ONES);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mphase_t;
  mphase_t      m_phase;
  logic [W-1:0] m_reload;
  logic         m_periodic, m_irqen, m_expired;
  int           m_presc, m_pwait, m_left;

  logic         e_tick, e_expiry, e_clken, e_load;
  logic [W-1:0] e_rd;

  task automatic model_reset();
    m_phase = M_IDLE; m_reload = '0; m_periodic = 0; m_irqen = 0;
    m_expired = 0; m_presc = 0; m_pwait = 0; m_left = 0;
  endtask

  task automatic model_eval();
    logic [W-1:0] st;
    st = '0;
`ifdef TIMER_PRESCALER_EN
    e_tick = (m_pwait == 0);
    st[15:8] = 8'(m_presc);
`else
    e_tick = 1'b1;
`endif
    e_expiry = (m_phase == M_RUN) && e_tick && (m_left == 1);
    e_clken  = (m_phase == M_LOAD) || ((m_phase == M_RUN) && e_tick);
    e_load   = (m_phase == M_LOAD) || (e_expiry && m_periodic);
    st[0] = (m_phase != M_IDLE);
    st[1] = m_expired;
    st[2] = m_irqen;
    e_rd  = regAddr ? st : cnt;
  endtask

  task automatic model_edge(input logic w, input logic a, input logic [W-1:0] d, input logic ack);
    mphase_t nph;
    nph = m_phase;
    if (m_phase == M_LOAD) m_pwait = m_presc;
    else if (m_phase == M_RUN) m_pwait = e_tick ? m_presc : m_pwait - 1;
    if (m_phase == M_LOAD) begin
      nph    = M_RUN;
      m_left = (1 << W) - int'(m_reload);
    end else if (m_phase == M_RUN && e_tick) begin
      if (m_left == 1) begin
        if (m_periodic) m_left = (1 << W) - int'(m_reload);
        else nph = M_DONE;
      end else begin
        m_left--;
      end
    end
    if (e_expiry) m_expired = 1'b1;
    else if (ack) m_expired = 1'b0;
    if (w && a) begin
      nph        = d[0] ? M_LOAD : M_IDLE;
      m_periodic = d[1];
      m_irqen    = d[2];
`ifdef TIMER_PRESCALER_EN
      m_presc    = int'(d[15:8]);
`endif
    end
    if (w && !a) m_reload = d;
    m_phase = nph;
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input logic w, input logic a, input logic [W-1:0] d, input logic ack);
    logic [W-1:0] nxt;
    regWrite = w; regAddr = a; regDataIn = d; irqAck = ack;
    @(negedge clk);
    model_eval();
    check("clken", W'(counterClkEn), W'(e_clken));
    check("load", counterLoad, {W{e_load}});
    check("valuein", counterValueIn, m_reload);
    check("irq", W'(irq), W'(m_expired & m_irqen));
    check("rdata", regDataOut, e_rd);
    nxt = cnt;
    if (counterClkEn) nxt = counterLoad[0] ? counterValueIn : cnt + 1'b1;
    @(posedge clk);
    #1;
    cnt = nxt;
    model_edge(w, a, d, ack);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic pulse_reset();
    regWrite = 0; regAddr = 1; irqAck = 0;
    @(negedge clk);
    #2 nReset = 0;
    #1;
    check("rst_irq", W'(irq), '0);
    check("rst_clken", W'(counterClkEn), '0);
    check("rst_load", counterLoad, '0);
    check("rst_valuein", counterValueIn, '0);
    check("rst_status", regDataOut, '0);
    model_reset();
    @(posedge clk);
    #1 nReset = 1;
  endtask

  initial begin
    logic [W-1:0] seq [4];
    int n;
    nReset = 1; regWrite = 0; regAddr = 1; regDataIn = '0; irqAck = 0;
    cnt = '0;
    model_reset();
    #2 nReset = 0;
    #1;
    check("init_irq", W'(irq), '0);
    check("init_clken", W'(counterClkEn), '0);
    check("init_load", counterLoad, '0);
    check("init_valuein", counterValueIn, '0);
    check("init_status", regDataOut, '0);
    repeat (2) @(posedge clk);
    #1 nReset = 1;

    // One-shot expiry
    cycle(1, 0, 16'hFFFC, 0);
    cycle(1, 1, 16'h0005, 0);
    cycle(0, 1, '0, 0);                 // LOAD
    check("os_loaded", cnt, 16'hFFFC);
    idle(3);
    check("os_irq_early", W'(irq), '0);
    idle(1);
    check("os_irq", W'(irq), 1);
    check("os_status", regDataOut, 16'h0007);
    idle(2);
    check("os_hold", cnt, 16'h0000);
    cycle(0, 1, '0, 1);
    check("os_ack", W'(irq), '0);

    // Periodic reload without gaps
    cycle(1, 0, 16'hFFFE, 0);
    cycle(1, 1, 16'h0003, 0);
    cycle(0, 0, '0, 0);                 // LOAD
    seq[0] = 16'hFFFF; seq[1] = 16'hFFFE; seq[2] = 16'hFFFF; seq[3] = 16'hFFFE;
    check("per_first", cnt, 16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, '0, 0);
      check("per_seq", cnt, seq[i]);
    end
    cycle(1, 1, 16'h0000, 1);
    cycle(0, 1, '0, 1);

    // Ack collides with expiry
    cycle(1, 0, 16'hFFFE, 0);
    cycle(1, 1, 16'h0005, 0);
    cycle(0, 1, '0, 0);                 // LOAD
    cycle(0, 1, '0, 0);                 // FFFE
    cycle(0, 1, '0, 1);                 // FFFF expiry + ack
    check("col_irq", W'(irq), 1);
    cycle(0, 1, '0, 1);
    check("col_clear", W'(irq), '0);

    // Disable at 0xFFF0
    cycle(1, 0, 16'hFF00, 0);
    cycle(1, 1, 16'h0001, 0);
    cycle(0, 0, '0, 0);                 // LOAD
    n = 0;
    while (cnt != 16'hFFF0 && n < 400) begin
      cycle(0, 0, '0, 0);
      n++;
    end
    check("dis_reach", cnt, 16'hFFF0);
    cycle(1, 1, 16'h0000, 0);
    idle(3);
    check("dis_freeze", cnt, 16'hFFF1);
    check("dis_status", regDataOut, '0);

    // Reset mid-run
    cycle(1, 0, 16'hFFF0, 0);
    cycle(1, 1, 16'h0007, 0);
    cycle(0, 1, '0, 0);                 // LOAD
    idle(3);
    pulse_reset();
    idle(3);
    check("rst_freeze", cnt, 16'hFFF3);

`ifdef TIMER_PRESCALER_EN
    // Prescaler P=3: expiry 4 cycles after LOAD
    cycle(1, 0, 16'hFFFF, 0);
    cycle(1, 1, 16'h0305, 0);
    cycle(0, 1, '0, 0);                 // LOAD
    idle(3);
    check("psc_early", W'(irq), '0);
    idle(1);
    check("psc_irq", W'(irq), 1);
    cycle(1, 1, 16'h0000, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic         w, a, k;
      logic [W-1:0] d;
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        w = ($urandom_range(0, 5) == 0);
        a = 1'($urandom_range(0, 1));
        k = ($urandom_range(0, 3) == 0);
        if (!a) begin
          d = ($urandom_range(0, 9) == 0) ? W'($urandom) : (16'hFFF0 | W'($urandom_range(0, 15)));
        end else begin
          d = W'($urandom);
          d[15:8] = 8'($urandom_range(0, 3));
          if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
        end
        cycle(w, a, d, k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
